// File: rtl/bayer_remosaic.sv
// rtl/bayer_remosaic.sv - 4 px/clk RGB to Bayer RAW re-mosaic with line length check
module bayer_remosaic #(
  parameter int         PIXEL_WIDTH     = 16,
  parameter logic [1:0] DEFAULT_PATTERN = 2'b00
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     frame_valid_i,
  input  logic                     line_valid_i,
  input  logic                     data_valid_i,
  input  logic [12*PIXEL_WIDTH-1:0] data_i,
  input  logic [1:0]               pattern_i,
  input  logic [10:0]              expected_words_i,
  output logic                     output_valid_o,
  output logic [4*PIXEL_WIDTH-1:0] output_o,
  output logic                     line_valid_o,
  output logic                     line_done_o,
  output logic                     length_error_o
);

  localparam int          PW       = PIXEL_WIDTH;
  localparam logic [10:0] WORD_MAX = 11'h7ff;

  logic              frame_valid_q;
  logic              line_valid_q;
  logic              line_parity;
  logic [1:0]        pattern_q;
  logic [10:0]       word_cnt;
  logic              s1_valid;
  logic              s1_parity;
  logic [12*PW-1:0]  s1_data;
  logic [4*PW-1:0]   mosaic;
  logic [3*PW-1:0]   px;
  logic              col;
  logic              green;
  logic              red;
  logic              frame_start;
  logic              line_end;
  logic              beat;

  assign frame_start = frame_valid_i & ~frame_valid_q;
  assign line_end    = line_valid_q & ~line_valid_i;
  assign beat        = data_valid_i & line_valid_i;

  // Frame start takes priority over a coincident line end.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      frame_valid_q  <= 1'b0;
      line_parity    <= 1'b0;
      pattern_q      <= DEFAULT_PATTERN;
      word_cnt       <= '0;
      length_error_o <= 1'b0;
    end else begin
      frame_valid_q <= frame_valid_i;
      if (frame_start) begin
        line_parity    <= 1'b0;
        pattern_q      <= pattern_i;
        length_error_o <= 1'b0;
        word_cnt       <= beat ? 11'd1 : 11'd0;
      end else if (line_end) begin
        line_parity <= ~line_parity;
        if (expected_words_i != 11'd0 && word_cnt != expected_words_i) begin
          length_error_o <= 1'b1;
        end
        word_cnt <= '0;
      end else if (beat && word_cnt != WORD_MAX) begin
        word_cnt <= word_cnt + 11'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_data      <= '0;
      s1_valid     <= 1'b0;
      s1_parity    <= 1'b0;
      line_valid_q <= 1'b0;
    end else begin
      s1_data      <= data_i;
      s1_valid     <= beat;
      s1_parity    <= frame_start ? 1'b0 : line_parity;
      line_valid_q <= line_valid_i;
    end
  end

  // Green sits where row^col differs from pattern[1]; red rows are those where row != pattern[0].
  always_comb begin
    mosaic = '0;
    px     = '0;
    col    = 1'b0;
    green  = 1'b0;
    red    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      px    = s1_data[(4-i)*3*PW-1 -: 3*PW];
      col   = (i % 2) == 1;
      green = (s1_parity ^ col) != pattern_q[1];
      red   = s1_parity != pattern_q[0];
      if (green) begin
        mosaic[(4-i)*PW-1 -: PW] = px[2*PW-1 -: PW];
      end else if (red) begin
        mosaic[(4-i)*PW-1 -: PW] = px[3*PW-1 -: PW];
      end else begin
        mosaic[(4-i)*PW-1 -: PW] = px[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      output_valid_o <= 1'b0;
      output_o       <= '0;
      line_valid_o   <= 1'b0;
      line_done_o    <= 1'b0;
    end else begin
      output_valid_o <= s1_valid;
      if (s1_valid) begin
        output_o <= mosaic;
      end
      line_valid_o <= line_valid_q;
      line_done_o  <= line_valid_o & ~line_valid_q;
    end
  end

endmodule

// File: tb/tb_bayer_remosaic.sv
// tb/tb_bayer_remosaic.sv - scoreboard bench for bayer_remosaic
module tb_bayer_remosaic;

  logic         clk_i = 1'b0;
  logic         reset_n_i = 1'b0;
  logic         frame_valid_i = 1'b0;
  logic         line_valid_i = 1'b0;
  logic         data_valid_i = 1'b0;
  logic [191:0] data_i = '0;
  logic [1:0]   pattern_i = 2'b00;
  logic [10:0]  expected_words_i = '0;
  logic         output_valid_o;
  logic [63:0]  output_o;
  logic         line_valid_o;
  logic         line_done_o;
  logic         length_error_o;

  bayer_remosaic #(.PIXEL_WIDTH(16), .DEFAULT_PATTERN(2'b00)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .frame_valid_i(frame_valid_i),
    .line_valid_i(line_valid_i), .data_valid_i(data_valid_i), .data_i(data_i),
    .pattern_i(pattern_i), .expected_words_i(expected_words_i),
    .output_valid_o(output_valid_o), .output_o(output_o), .line_valid_o(line_valid_o),
    .line_done_o(line_done_o), .length_error_o(length_error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         failed = 0;
  int         cyc = 0;
  logic [3:0] hist = '0;
  logic       s_err = 1'b0;
  logic       s_valid = 1'b0;
  logic [1:0] m_pat = 2'b00;
  logic       m_row = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // 0=R 1=G 2=B for {pattern,row,col}
  function automatic int cfa_ch(input logic [3:0] key);
    case (key)
      4'b0000: return 2; 4'b0001: return 1; 4'b0010: return 1; 4'b0011: return 0;
      4'b0100: return 0; 4'b0101: return 1; 4'b0110: return 1; 4'b0111: return 2;
      4'b1000: return 1; 4'b1001: return 2; 4'b1010: return 0; 4'b1011: return 1;
      4'b1100: return 1; 4'b1101: return 0; 4'b1110: return 2; default: return 1;
    endcase
  endfunction

  function automatic logic [63:0] model(input logic [191:0] d, input logic [1:0] pat, input logic row);
    logic [63:0] r;
    logic [47:0] p;
    int          ch;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      p  = d[191-48*i -: 48];
      ch = cfa_ch({pat, row, (i % 2) == 1});
      r[63-16*i -: 16] = (ch == 0) ? p[47:32] : (ch == 1) ? p[31:16] : p[15:0];
    end
    return r;
  endfunction

  task automatic tick();
    exp_t e;
    @(negedge clk_i);
    hist    = {hist[2:0], reset_n_i ? line_valid_i : 1'b0};
    s_err   = length_error_o;
    s_valid = output_valid_o;
    if (reset_n_i) begin
      if (output_valid_o) begin
        tests++;
        if (sb.size() == 0) begin
          failed++;
          $display("FAIL unexpected_beat cyc=%0d got=%h expected=no beat", cyc, output_o);
        end else begin
          e = sb.pop_front();
          if (output_o !== e.data || cyc != e.cyc) begin
            failed++;
            $display("FAIL beat got=%h@%0d expected=%h@%0d", output_o, cyc, e.data, e.cyc);
          end
        end
      end
      tests++;
      if ({line_valid_o, line_done_o} !== {hist[2], hist[3] & ~hist[2]}) begin
        failed++;
        $display("FAIL line_timing cyc=%0d got lv/done=%b%b expected=%b%b",
                 cyc, line_valid_o, line_done_o, hist[2], hist[3] & ~hist[2]);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_beat();
    exp_t e;
    data_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    e.data = model(data_i, m_pat, m_row);
    e.cyc  = cyc + 2;
    sb.push_back(e);
  endtask

  // gaps bit k = 1 inserts an idle cycle at line cycle k
  task automatic drive_line(input int n, input logic [31:0] gaps);
    int sent = 0;
    int k = 0;
    while (sent < n) begin
      line_valid_i = 1'b1;
      data_valid_i = ~gaps[k % 32];
      if (data_valid_i) begin
        push_beat();
        sent++;
      end else begin
        data_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      k++;
      tick();
    end
    line_valid_i = 1'b0;
    data_valid_i = 1'b0;
    tick();
    m_row = ~m_row;
  endtask

  task automatic drive_fixed(input logic [63:0] exp_word, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      line_valid_i = 1'b1;
      data_valid_i = 1'b1;
      data_i = {4{48'h1111_2222_3333}};
      e.data = exp_word;
      e.cyc  = cyc + 2;
      sb.push_back(e);
      tick();
    end
    line_valid_i = 1'b0;
    data_valid_i = 1'b0;
    tick();
    m_row = ~m_row;
  endtask

  task automatic frame_begin(input logic [1:0] pat);
    frame_valid_i = 1'b1;
    pattern_i     = pat;
    line_valid_i  = 1'b0;
    data_valid_i  = 1'b0;
    tick();
    m_pat = pat;
    m_row = 1'b0;
  endtask

  task automatic frame_end();
    frame_valid_i = 1'b0;
    idle(2);
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    idle(2);
    tests++;
    if (output_o !== 64'h0 || output_valid_o !== 1'b0) begin
      failed++;
      $display("FAIL reset_out got=%h/%b expected=0/0", output_o, output_valid_o);
    end
    tests++;
    if ({line_valid_o, line_done_o, length_error_o} !== 3'b000) begin
      failed++;
      $display("FAIL reset_flags got=%b%b%b expected=000", line_valid_o, line_done_o, length_error_o);
    end
    reset_n_i = 1'b1;
    idle(2);
  endtask

  task automatic test_bggr();
    expected_words_i = '0;
    frame_begin(2'b00);
    drive_fixed(64'h3333_2222_3333_2222, 3);
    idle(2);
    drive_fixed(64'h2222_1111_2222_1111, 2);
    idle(3);
    frame_end();
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL bggr_drain got=%0d pending expected=0", sb.size());
    end
  endtask

  task automatic test_patterns();
    for (int p = 1; p < 4; p++) begin
      frame_begin(2'(p));
      drive_line(2, 32'h0);
      pattern_i = ~2'(p);
      idle(2);
      drive_line(2, 32'h2);
      drive_line(1, 32'h0);
      idle(1);
      frame_end();
    end
    idle(2);
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL patterns_drain got=%0d pending expected=0", sb.size());
    end
  endtask

  task automatic test_length();
    expected_words_i = 11'd8;
    frame_begin(2'b01);
    drive_line(8, 32'h0);
    idle(2);
    tests++;
    if (s_err !== 1'b0) begin failed++; $display("FAIL len_ok got=%b expected=0", s_err); end
    drive_line(7, 32'h0);
    tests++;
    if (s_err !== 1'b0) begin failed++; $display("FAIL len_latency got=%b expected=0", s_err); end
    tick();
    tests++;
    if (s_err !== 1'b1) begin failed++; $display("FAIL len_set got=%b expected=1", s_err); end
    drive_line(9, 32'h0);
    idle(2);
    frame_end();
    tests++;
    if (s_err !== 1'b1) begin failed++; $display("FAIL len_sticky got=%b expected=1", s_err); end
    frame_begin(2'b01);
    tick();
    tests++;
    if (s_err !== 1'b0) begin failed++; $display("FAIL len_clear got=%b expected=0", s_err); end
    expected_words_i = '0;
    drive_line(7, 32'h0);
    drive_line(9, 32'h0);
    idle(2);
    tests++;
    if (s_err !== 1'b0) begin failed++; $display("FAIL len_disabled got=%b expected=0", s_err); end
    frame_end();
  endtask

  task automatic test_gaps();
    expected_words_i = 11'd5;
    frame_begin(2'b10);
    repeat (3) begin
      line_valid_i = 1'b0;
      data_valid_i = 1'b1;
      data_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tick();
    end
    data_valid_i = 1'b0;
    tick();
    drive_line(5, 32'b1011_0010);
    idle(2);
    tests++;
    if (s_err !== 1'b0) begin failed++; $display("FAIL gap_count got=%b expected=0", s_err); end
    frame_end();
  endtask

  task automatic test_same_cycle();
    expected_words_i = '0;
    frame_begin(2'b11);
    drive_line(3, 32'h0);
    frame_end();
    // frame and line rise together after an odd-parity state
    frame_valid_i = 1'b1;
    pattern_i     = 2'b11;
    m_pat         = 2'b11;
    m_row         = 1'b0;
    line_valid_i  = 1'b1;
    data_valid_i  = 1'b1;
    push_beat();
    tick();
    drive_line(2, 32'h0);
    line_valid_i = 1'b1;
    data_valid_i = 1'b1;
    push_beat();
    tick();
    frame_valid_i = 1'b0;
    data_valid_i  = 1'b0;
    tick();
    // line end coincides with the next frame start
    frame_valid_i = 1'b1;
    line_valid_i  = 1'b0;
    pattern_i     = 2'b01;
    tick();
    m_pat = 2'b01;
    m_row = 1'b0;
    drive_line(2, 32'h0);
    idle(3);
    frame_end();
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL same_cycle_drain got=%0d pending expected=0", sb.size());
    end
  endtask

  task automatic test_reset_midline();
    expected_words_i = 11'd4;
    frame_begin(2'b11);
    drive_line(2, 32'h0);
    idle(2);
    tests++;
    if (s_err !== 1'b1) begin failed++; $display("FAIL err_before_reset got=%b expected=1", s_err); end
    line_valid_i = 1'b1;
    data_valid_i = 1'b1;
    push_beat();
    tick();
    push_beat();
    tick();
    tests++;
    if (output_valid_o !== 1'b1) begin
      failed++;
      $display("FAIL inflight_present got=%b expected=1", output_valid_o);
    end
    #1 reset_n_i = 1'b0;
    #1;
    tests++;
    if ({output_valid_o, line_valid_o, line_done_o, length_error_o} !== 4'b0000 || output_o !== 64'h0) begin
      failed++;
      $display("FAIL async_reset got=%b%b%b%b/%h expected=0000/0",
               output_valid_o, line_valid_o, line_done_o, length_error_o, output_o);
    end
    sb.delete();
    hist          = '0;
    line_valid_i  = 1'b0;
    data_valid_i  = 1'b0;
    frame_valid_i = 1'b0;
    pattern_i     = 2'b11;
    expected_words_i = '0;
    idle(2);
    reset_n_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if (s_valid !== 1'b0) begin failed++; $display("FAIL no_glitch got=%b expected=0", s_valid); end
    end
    m_pat = 2'b00;
    m_row = 1'b0;
    drive_line(2, 32'h0);
    idle(1);
    frame_begin(2'b11);
    drive_line(2, 32'h0);
    idle(3);
    frame_end();
  endtask

  initial begin
    test_reset();
    test_bggr();
    test_patterns();
    test_length();
    test_gaps();
    test_same_cycle();
    test_reset_midline();
    idle(4);
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL final_drain got=%0d pending expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
